ddr5_phy_crc_gen: RTL and testbench

Parametrised DDR5 write-CRC generator and successor to the fixed x4 CRC block. It computes CRC-8 (polynomial x^8+x^2+x+1, 0x07) independently on NUM_CH channels over a frame of BEATS data words, each DATA_W bits wide per channel. Features:
- Configurable device width (x4/x8/x16 via NUM_CH and DATA_W).
- Back-to-back frames with no bubble cycle.
- Synchronous frame abort.
- Registered, held result with a valid pulse.

It sits between the write-data block and the DQ serialiser, which appends crc_o to the burst.

---
 rtl/ddr5_phy_crc_gen.sv | 111 +++++++++++
 tb/tb_ddr5_phy_crc_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_phy_crc_gen.sv
// ddr5_phy_crc_gen
// Parametrised DDR5 write-CRC generator. Computes CRC-8 (poly 0x07, no
// reflection, no final XOR) independently on NUM_CH channels over a frame of
// BEATS accepted data words. Each word is DATA_W bits per channel and is
// folded in with a single-cycle parallel step, MSB first. Frames can run back
// to back. The completed CRC is registered and held, and a one-cycle valid
// pulse marks each update.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-low reset
//   clr_i      : synchronous frame abort (drops partial frame, ignores data_i)
//   en_i       : beat valid; data_i consumed when en_i=1 and clr_i=0
//   data_i     : beat data, channel k at [k*DATA_W +: DATA_W]
//   crc_o      : last completed CRC, channel k at [k*8 +: 8]
//   crc_vld_o  : one-cycle pulse, crc_o updated this cycle
//   busy_o     : frame partially accumulated
//   beat_cnt_o : beats accepted in the current frame
module ddr5_phy_crc_gen #(
  parameter int         NUM_CH   = 1,
  parameter int         DATA_W   = 8,
  parameter int         BEATS    = 8,
  parameter logic [7:0] CRC_INIT = 8'h00,
  localparam int        CNT_W    = $clog2(BEATS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic [NUM_CH*DATA_W-1:0]   data_i,
  output logic [NUM_CH*8-1:0]        crc_o,
  output logic                       crc_vld_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           beat_cnt_o
);

  localparam logic [NUM_CH*8-1:0] ACC_INIT = {NUM_CH{CRC_INIT}};
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(BEATS - 1);

  logic [NUM_CH*8-1:0] acc_q, acc_d;
  logic [NUM_CH*8-1:0] crc_q, crc_d;
  logic [NUM_CH*8-1:0] acc_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic                last_beat;

  // Unrolled serial CRC: the loop collapses into an XOR network that folds a
  // whole DATA_W-bit slice into the register in one cycle.
  function automatic logic [7:0] crc_step(input logic [7:0] crc_in,
                                          input logic [DATA_W-1:0] din);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = din[i] ^ c[7];
      c  = {c[6:0], 1'b0} ^ ({8{fb}} & 8'h07);
    end
    return c;
  endfunction

  always_comb begin
    acc_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      acc_nxt[k*8 +: 8] = crc_step(acc_q[k*8 +: 8], data_i[k*DATA_W +: DATA_W]);
    end
  end

  assign last_beat = (cnt_q == LAST_CNT);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    crc_d = crc_q;
    vld_d = 1'b0;
    if (clr_i) begin
      // Abort wins over a coinciding completion: crc_q keeps its old value.
      acc_d = ACC_INIT;
      cnt_d = '0;
    end else if (en_i) begin
      if (last_beat) begin
        crc_d = acc_nxt;
        vld_d = 1'b1;
        acc_d = ACC_INIT;
        cnt_d = '0;
      end else begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= ACC_INIT;
      cnt_q <= '0;
      crc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      crc_q <= crc_d;
      vld_q <= vld_d;
    end
  end

  assign crc_o      = crc_q;
  assign crc_vld_o  = vld_q;
  assign beat_cnt_o = cnt_q;
  assign busy_o     = (cnt_q != '0);

endmodule

// File: tb/tb_ddr5_phy_crc_gen.sv
// Testbench for ddr5_phy_crc_gen. Seven parameter sets share one stimulus
// bus; each has a frame-level model (beats queued, CRC computed bit-serially
// over the whole frame on completion) checked every cycle, plus directed
// literal checks.
module tb_ddr5_phy_crc_gen;

  localparam int NCFG = 7;
  // config index:          6      5      4      3      2      1      0
  localparam logic [55:0] NC_T = {8'd1,  8'd2,  8'd4,  8'd2,  8'd1,  8'd1,  8'd1};
  localparam logic [55:0] DW_T = {8'd4,  8'd8,  8'd4,  8'd4,  8'd8,  8'd8,  8'd8};
  localparam logic [55:0] BT_T = {8'd16, 8'd8,  8'd16, 8'd16, 8'd9,  8'd1,  8'd8};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] data = '0;

  logic [31:0] crc_all  [NCFG];
  logic        vld_all  [NCFG];
  logic        busy_all [NCFG];
  logic [7:0]  cnt_all  [NCFG];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_bits(input logic [7:0] c_in,
                                          input logic [15:0] d, input int w);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = w - 1; i >= 0; i--) begin
      fb = d[i] ^ c[7];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [31:0] frame_crc(input logic [15:0] qq[$],
                                            input int nc, input int dw);
    logic [31:0] r;
    logic [7:0]  c;
    r = '0;
    for (int ch = 0; ch < nc; ch++) begin
      c = 8'h00;
      for (int b = 0; b < qq.size(); b++) c = crc_bits(c, qq[b] >> (ch * dw), dw);
      r[ch*8 +: 8] = c;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NC = int'(NC_T[g*8 +: 8]);
    localparam int DW = int'(DW_T[g*8 +: 8]);
    localparam int BT = int'(BT_T[g*8 +: 8]);
    localparam int CW = $clog2(BT + 1);

    logic [NC*8-1:0] crc_w;
    logic            vld_w;
    logic            busy_w;
    logic [CW-1:0]   cnt_w;

    ddr5_phy_crc_gen #(
      .NUM_CH(NC), .DATA_W(DW), .BEATS(BT), .CRC_INIT(8'h00)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en),
      .data_i(data[NC*DW-1:0]),
      .crc_o(crc_w), .crc_vld_o(vld_w), .busy_o(busy_w), .beat_cnt_o(cnt_w)
    );

    assign crc_all[g]  = 32'(crc_w);
    assign vld_all[g]  = vld_w;
    assign busy_all[g] = busy_w;
    assign cnt_all[g]  = 8'(cnt_w);

    logic [15:0] q[$];
    logic [31:0] m_crc = '0;
    logic        m_vld = 1'b0;

    initial begin
      forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
          q.delete();
          m_crc = '0;
          m_vld = 1'b0;
        end else begin
          m_vld = 1'b0;
          if (clr) q.delete();
          else if (en) begin
            q.push_back(data);
            if (q.size() == BT) begin
              m_crc = frame_crc(q, NC, DW);
              m_vld = 1'b1;
              q.delete();
            end
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        chk($sformatf("cfg%0d crc_o", g), crc_all[g], m_crc);
        chk($sformatf("cfg%0d crc_vld_o", g), 32'(vld_all[g]), 32'(m_vld));
        chk($sformatf("cfg%0d beat_cnt_o", g), 32'(cnt_all[g]), 32'(q.size()));
        chk($sformatf("cfg%0d busy_o", g), 32'(busy_all[g]), 32'(q.size() != 0));
      end
    end
  end

  // Present one input set, let one rising edge consume it, return 2 time units
  // after that edge with enable/abort dropped.
  task automatic drive(input logic [15:0] d, input logic e, input logic c);
    data = d;
    en   = e;
    clr  = c;
    @(posedge clk);
    #2;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("%s cfg%0d crc", nm, g), crc_all[g], 32'h0);
      chk($sformatf("%s cfg%0d vld/busy/cnt", nm, g),
          {vld_all[g], busy_all[g], cnt_all[g]}, 32'h0);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  logic [7:0]  fr [8] = '{8'h12, 8'h34, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'hC3, 8'h81};
  logic [15:0] fq[$];
  logic [31:0] ref_f;
  logic [31:0] ref_ones;
  int          p0, p1, n4;

  initial begin
    #1 rst = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    #1 rst = 1'b1;

    // BEATS=1 single byte frames
    drive(16'h0001, 1'b1, 1'b0);
    chk("b1 crc 01", crc_all[1], 32'h07);
    chk("b1 vld 01", 32'(vld_all[1]), 32'h1);
    chk("b1 cnt", 32'(cnt_all[1]), 32'h0);
    chk("def cnt after 1", 32'(cnt_all[0]), 32'h1);
    drive(16'h00FF, 1'b1, 1'b0);
    chk("b1 crc FF", crc_all[1], 32'hF3);
    chk("b1 vld FF", 32'(vld_all[1]), 32'h1);
    drive(16'h0000, 1'b0, 1'b0);
    chk("b1 vld idle", 32'(vld_all[1]), 32'h0);
    chk("b1 crc hold", crc_all[1], 32'hF3);

    // "123456789" with gaps, BEATS=9
    mid_reset();
    for (int b = 0; b < 9; b++) begin
      repeat ($urandom_range(0, 2)) drive(16'h0000, 1'b0, 1'b0);
      drive(16'(8'h31 + b), 1'b1, 1'b0);
      chk($sformatf("b9 cnt beat%0d", b), 32'(cnt_all[2]), 32'((b + 1) % 9));
      chk($sformatf("b9 busy beat%0d", b), 32'(busy_all[2]), 32'(b < 8));
    end
    chk("b9 check string crc", crc_all[2], 32'hF4);
    chk("b9 vld", 32'(vld_all[2]), 32'h1);

    // two channels of 4 bits, back-to-back 16-beat frames
    mid_reset();
    fq.delete();
    for (int b = 0; b < 16; b++) fq.push_back(16'h000F);
    ref_ones = frame_crc(fq, 1, 4);
    p0 = -1;
    p1 = -1;
    for (int i = 0; i < 32; i++) begin
      drive(16'h00F0, 1'b1, 1'b0);
      if (vld_all[3]) begin
        if (p0 < 0) p0 = i;
        else if (p1 < 0) p1 = i;
      end
    end
    chk("x2 first pulse beat", 32'(p0), 32'd15);
    chk("x2 pulse spacing", 32'(p1 - p0), 32'd16);
    chk("x2 ch0 zero", 32'(crc_all[3][7:0]), 32'h0);
    chk("x2 ch1 serial", 32'(crc_all[3][15:8]), 32'(ref_ones[7:0]));
    chk("x4 ch0 zero", 32'(crc_all[4][7:0]), 32'h0);

    // abort after 5 beats on default config
    mid_reset();
    fq.delete();
    for (int b = 0; b < 8; b++) fq.push_back({8'h00, fr[b]});
    ref_f = frame_crc(fq, 1, 8);
    for (int b = 0; b < 8; b++) drive({8'h00, fr[b]}, 1'b1, 1'b0);
    chk("def frame from reset", crc_all[0], ref_f);
    for (int b = 0; b < 5; b++) drive(16'h0077 + 16'(b), 1'b1, 1'b0);
    drive(16'h00AA, 1'b1, 1'b1);
    chk("abort no vld", 32'(vld_all[0]), 32'h0);
    chk("abort cnt", 32'(cnt_all[0]), 32'h0);
    chk("abort crc held", crc_all[0], ref_f);
    for (int b = 0; b < 8; b++) drive({8'h00, fr[b]}, 1'b1, 1'b0);
    chk("frame after abort", crc_all[0], ref_f);
    chk("frame after abort vld", 32'(vld_all[0]), 32'h1);

    // abort on the completing beat
    for (int b = 0; b < 7; b++) drive(16'h0033 ^ 16'(b), 1'b1, 1'b0);
    drive(16'h0099, 1'b1, 1'b1);
    chk("clr on last no vld", 32'(vld_all[0]), 32'h0);
    chk("clr on last crc held", crc_all[0], ref_f);

    // reset mid-frame, then a clean frame
    for (int b = 0; b < 3; b++) drive(16'h0044, 1'b1, 1'b0);
    mid_reset();
    for (int b = 0; b < 8; b++) drive({8'h00, fr[b]}, 1'b1, 1'b0);
    chk("frame after rst", crc_all[0], ref_f);

    // random traffic across all configs
    n4 = 0;
    for (int cyc = 0; cyc < 40000 && n4 < 1000; cyc++) begin
      drive(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 255) == 0));
      if (vld_all[4]) n4++;
    end
    chk("random x4 frames reached", 32'(n4 >= 1000), 32'h1);

    repeat (3) drive(16'h0000, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
